ahb_cfg_regs: RTL and testbench
===============================

AHB_CFG_REGS -- requirements
Module: ahb_cfg_regs

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32: AHB address and data width, minimum 32.
REQ-002 SHALL have parameter NUM_CHAN, default 2: number of independent filter-channel register sets, range 1..15.
REQ-003 SHALL reset on n_rst, asynchronous, active-low, and be clocked by ahb_hclk.
REQ-004 SHALL have these ports, one per line (name  direction  width  meaning):
- ahb_hclk  in  1  bus clock
- n_rst  in  1  async active-low reset
- ahb_hsel  in  1  slave select from external decoder
- ahb_htrans  in  2  transfer type (NONSEQ=10, SEQ=11 valid)
- ahb_hwrite  in  1  1=write
- ahb_hsize  in  3  transfer size
- ahb_haddr  in  BUSWIDTH  address; only [8:0] decoded
- ahb_hwdata  in  BUSWIDTH  write data (data phase)
- ahb_hready_in  in  1  bus-level HREADY
- ahb_hreadyout  out  1  slave ready
- ahb_hresp  out  1  0=OKAY, 1=ERROR
- ahb_hrdata  out  BUSWIDTH  read data
- cfg_width  out  NUM_CHAN*BUSWIDTH  per-channel width, channel c at [c*BUSWIDTH +: BUSWIDTH]
- cfg_height  out  NUM_CHAN*BUSWIDTH  per-channel height
- cfg_rd_addr  out  NUM_CHAN*BUSWIDTH  per-channel read start address
- cfg_wr_addr  out  NUM_CHAN*BUSWIDTH  per-channel write start address
- cfg_filter  out  NUM_CHAN  per-channel filter type
- final_enable  out  1  processing run active
- done_i  in  1  single-cycle pulse: downstream run complete

Function
REQ-005 SHALL accept an address phase only when ahb_hsel=1, ahb_htrans[1]=1 and ahb_hready_in=1; SHALL register index, direction and legality for the following data phase.
REQ-006 SHALL use this register map (byte offset, word aligned): 0x000 CTRL (write: bit0 START, self-clearing), 0x004 STATUS (read-only), then channel c at 0x010+0x20*c with +0x0 WIDTH, +0x4 HEIGHT, +0x8 RD_ADDR, +0xC WR_ADDR, +0x10 FILTER (bit0).
REQ-007 SHALL complete legal transfers with zero wait states: ahb_hreadyout=1, ahb_hresp=0.
REQ-008 SHALL issue a two-cycle ERROR response (cycle 1: hreadyout=0, hresp=1; cycle 2: hreadyout=1, hresp=1) for: unmapped offset, ahb_hsize!=3'b010, write to STATUS, WIDTH or HEIGHT write of value 0, any channel-register write while in RUN, and START while not IDLE or not all channels valid.
REQ-009 SHALL leave register contents unchanged on an ERROR transfer and SHALL set sticky STATUS[31].
REQ-010 SHALL set per-channel valid bit c once both WIDTH and HEIGHT of channel c have been written nonzero; valid bits SHALL persist until reset.
REQ-011 SHALL implement run FSM IDLE->RUN on a legal START data phase, with final_enable=1 from the next cycle; RUN->IDLE on done_i=1, with final_enable=0 from the next cycle; done_i in IDLE is ignored.
REQ-012 SHALL evaluate START against the state in the data-phase cycle; START coincident with done_i in RUN SHALL get ERROR and the FSM SHALL go to IDLE.
REQ-013 SHALL return STATUS as bit0=RUN, bits[NUM_CHAN:1]=valid mask, bit31=sticky error, other bits 0; a STATUS read SHALL clear bit31 after returning it.
REQ-014 SHALL ignore IDLE/BUSY transfers (OKAY, no side effect) and SHALL correctly handle back-to-back SEQ transfers.

Reset
REQ-015 On n_rst=0 SHALL go to IDLE with all cfg_* outputs 0, final_enable=0, valid mask 0, STATUS[31]=0, ahb_hreadyout=1, ahb_hresp=0, ahb_hrdata=0; any in-flight transfer and ERROR sequence SHALL be abandoned.

Configuration
REQ-016 With AHB_CFG_READBACK_EN defined, reads SHALL return the addressed register (CTRL reads 0) in the data phase; without it, ahb_hrdata SHALL be constant 0, reads SHALL get OKAY, and STATUS[31] SHALL be cleared only by reset.

Verification
REQ-017 Write ch0 WIDTH=640, HEIGHT=480 and ch1 WIDTH=320, HEIGHT=240, then START -> OKAY on each write, final_enable=1 one cycle after START data phase.
REQ-018 START with only ch0 valid -> two-cycle ERROR, final_enable stays 0, STATUS[31]=1.
REQ-019 Write ch1 RD_ADDR=0x1000 during RUN -> ERROR, cfg_rd_addr ch1 unchanged; done_i pulse -> final_enable=0 next cycle.
REQ-020 Write WIDTH=0 and a byte-size (hsize=000) write to 0x010 -> ERROR on both, cfg_width ch0 unchanged.
REQ-021 With AHB_CFG_READBACK_EN defined, read STATUS after REQ-018 -> 0x80000002, a second read returns 0x00000002; assert n_rst mid-RUN -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/ahb_cfg_regs.sv
// ahb_cfg_regs: AHB-Lite slave holding per-channel filter configuration
// (width, height, read/write start address, filter type) plus a CTRL/STATUS
// pair that starts a processing run and reports run state, per-channel valid
// bits and a sticky bus-error flag.
//
// Optional feature macro: AHB_CFG_READBACK_EN
//   defined   : reads return the addressed register; a STATUS read clears
//               the sticky error bit after returning it.
//   undefined : ahb_hrdata is constant 0 and the sticky error bit is cleared
//               only by reset.
//
// Bus handshake: an address phase is taken when ahb_hsel, ahb_htrans[1] and
// ahb_hready_in are all 1. The following cycle is its data phase. A legal
// data phase completes in that cycle (hreadyout=1, hresp=0) and commits its
// side effects at the closing edge. An illegal one stretches to two cycles:
// (hreadyout=0, hresp=1) then (hreadyout=1, hresp=1), with no register
// change other than the sticky error flag.
module ahb_cfg_regs #(
   parameter int BUSWIDTH = 32,
   parameter int NUM_CHAN = 2
) (
   input  logic                         ahb_hclk,
   input  logic                         n_rst,
   input  logic                         ahb_hsel,
   input  logic [1:0]                   ahb_htrans,
   input  logic                         ahb_hwrite,
   input  logic [2:0]                   ahb_hsize,
   input  logic [BUSWIDTH-1:0]          ahb_haddr,
   input  logic [BUSWIDTH-1:0]          ahb_hwdata,
   input  logic                         ahb_hready_in,
   output logic                         ahb_hreadyout,
   output logic                         ahb_hresp,
   output logic [BUSWIDTH-1:0]          ahb_hrdata,
   output logic [NUM_CHAN*BUSWIDTH-1:0] cfg_width,
   output logic [NUM_CHAN*BUSWIDTH-1:0] cfg_height,
   output logic [NUM_CHAN*BUSWIDTH-1:0] cfg_rd_addr,
   output logic [NUM_CHAN*BUSWIDTH-1:0] cfg_wr_addr,
   output logic [NUM_CHAN-1:0]          cfg_filter,
   output logic                         final_enable,
   input  logic                         done_i
);

   localparam logic [4:0] NUM_CHAN_L = 5'(NUM_CHAN);

   // Register index inside one channel block (byte offset / 4).
   localparam logic [2:0] SUB_WIDTH  = 3'd0;
   localparam logic [2:0] SUB_HEIGHT = 3'd1;
   localparam logic [2:0] SUB_RD     = 3'd2;
   localparam logic [2:0] SUB_WR     = 3'd3;
   localparam logic [2:0] SUB_FILTER = 3'd4;

   typedef enum logic [1:0] {
      K_CTRL   = 2'd0,
      K_STATUS = 2'd1,
      K_CHAN   = 2'd2
   } kind_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Address-phase decode
   logic [8:0] a_off;
   logic [8:0] a_rel;
   logic [3:0] a_ch;
   logic [2:0] a_sub;
   logic       a_ctrl;
   logic       a_status;
   logic       a_chan;
   logic       a_mapped;
   logic       a_accept;
   kind_t      a_kind;

   // Registered data-phase context
   logic       dph_valid;
   logic       dph_write;
   logic       dph_ok;
   kind_t      dph_kind;
   logic [3:0] dph_ch;
   logic [2:0] dph_sub;

   // Data-phase evaluation
   logic wh_write;
   logic start_bit;
   logic illegal;
   logic err_now;
   logic dph_go;
   logic wr_go;
   logic start_go;
   logic status_clr;

   // Register storage
   logic [BUSWIDTH-1:0] width_q   [NUM_CHAN];
   logic [BUSWIDTH-1:0] height_q  [NUM_CHAN];
   logic [BUSWIDTH-1:0] rd_addr_q [NUM_CHAN];
   logic [BUSWIDTH-1:0] wr_addr_q [NUM_CHAN];
   logic [NUM_CHAN-1:0] filter_q;
   logic [NUM_CHAN-1:0] w_set_q;
   logic [NUM_CHAN-1:0] h_set_q;
   logic [NUM_CHAN-1:0] chan_valid;
   logic                all_valid;
   logic                sticky_q;
   logic                err2_q;

   // Only the low nine address bits are decoded; htrans[0] (SEQ vs NONSEQ)
   // makes no difference to this slave.
   logic unused_bits;
   assign unused_bits = ^{ahb_haddr[BUSWIDTH-1:9], ahb_htrans[0], a_rel[1:0]};

   // Decode the presented address into register kind, channel and sub-index
   always_comb begin
      a_off    = ahb_haddr[8:0];
      a_rel    = a_off - 9'h010;
      a_ch     = a_rel[8:5];
      a_sub    = a_rel[4:2];
      a_ctrl   = (a_off == 9'h000);
      a_status = (a_off == 9'h004);
      a_chan   = (a_off >= 9'h010) && (a_off[1:0] == 2'b00) &&
                 ({1'b0, a_ch} < NUM_CHAN_L) && (a_sub <= SUB_FILTER);
      a_mapped = a_ctrl || a_status || a_chan;
      a_kind   = K_CTRL;
      if (a_status) begin
         a_kind = K_STATUS;
      end else if (a_chan) begin
         a_kind = K_CHAN;
      end
   end

   assign a_accept = ahb_hsel && ahb_htrans[1] && ahb_hready_in;

   // Capture the accepted address phase for use in the following data phase
   always_ff @(posedge ahb_hclk or negedge n_rst) begin
      if (!n_rst) begin
         dph_valid <= 1'b0;
         dph_write <= 1'b0;
         dph_ok    <= 1'b0;
         dph_kind  <= K_CTRL;
         dph_ch    <= 4'd0;
         dph_sub   <= 3'd0;
      end else if (ahb_hready_in) begin
         dph_valid <= a_accept;
         dph_write <= ahb_hwrite;
         dph_ok    <= a_mapped && (ahb_hsize == 3'b010);
         dph_kind  <= a_kind;
         dph_ch    <= a_ch;
         dph_sub   <= a_sub;
      end else if (err_now) begin
         dph_valid <= 1'b0;
      end
   end

   // Legality depends on write data and run state, so it is judged in the
   // data phase itself rather than at address time.
   always_comb begin
      wh_write  = dph_write && (dph_kind == K_CHAN) &&
                  ((dph_sub == SUB_WIDTH) || (dph_sub == SUB_HEIGHT));
      start_bit = dph_write && (dph_kind == K_CTRL) && ahb_hwdata[0];
      illegal   = !dph_ok ||
                  (dph_write && (dph_kind == K_STATUS)) ||
                  (wh_write && (ahb_hwdata == '0)) ||
                  (dph_write && (dph_kind == K_CHAN) && (state_q == S_RUN)) ||
                  (start_bit && ((state_q != S_IDLE) || !all_valid));
      err_now   = dph_valid && illegal;
      dph_go    = dph_valid && !illegal;
      wr_go     = dph_go && dph_write;
      start_go  = wr_go && start_bit;
   end

   // Channel configuration registers, written only by legal data phases
   always_ff @(posedge ahb_hclk or negedge n_rst) begin
      if (!n_rst) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            width_q[c]   <= '0;
            height_q[c]  <= '0;
            rd_addr_q[c] <= '0;
            wr_addr_q[c] <= '0;
         end
         filter_q <= '0;
      end else if (wr_go && (dph_kind == K_CHAN)) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            if (dph_ch == 4'(c)) begin
               case (dph_sub)
                  SUB_WIDTH:  width_q[c]   <= ahb_hwdata;
                  SUB_HEIGHT: height_q[c]  <= ahb_hwdata;
                  SUB_RD:     rd_addr_q[c] <= ahb_hwdata;
                  SUB_WR:     wr_addr_q[c] <= ahb_hwdata;
                  SUB_FILTER: filter_q[c]  <= ahb_hwdata[0];
                  default:    ;
               endcase
            end
         end
      end
   end

   // Per-channel "written nonzero" flags; they persist until reset
   always_ff @(posedge ahb_hclk or negedge n_rst) begin
      if (!n_rst) begin
         w_set_q <= '0;
         h_set_q <= '0;
      end else if (wr_go && (dph_kind == K_CHAN)) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            if (dph_ch == 4'(c)) begin
               if (dph_sub == SUB_WIDTH) begin
                  w_set_q[c] <= 1'b1;
               end
               if (dph_sub == SUB_HEIGHT) begin
                  h_set_q[c] <= 1'b1;
               end
            end
         end
      end
   end

   assign chan_valid = w_set_q & h_set_q;
   assign all_valid  = &chan_valid;

   // Run FSM: state register
   always_ff @(posedge ahb_hclk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Run FSM: next state (START only ever succeeds from IDLE, so a START
   // coincident with done_i in RUN is an error and done_i wins)
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_go) state_d = S_RUN;
         S_RUN:   if (done_i)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Run FSM: outputs
   always_comb begin
      final_enable = (state_q == S_RUN);
   end

   // Sticky error flag and second ERROR cycle marker
   always_ff @(posedge ahb_hclk or negedge n_rst) begin
      if (!n_rst) begin
         sticky_q <= 1'b0;
         err2_q   <= 1'b0;
      end else begin
         err2_q <= err_now;
         if (err_now) begin
            sticky_q <= 1'b1;
         end else if (status_clr) begin
            sticky_q <= 1'b0;
         end
      end
   end

   assign ahb_hreadyout = !err_now;
   assign ahb_hresp     = err_now || err2_q;

   // Flatten channel registers onto the packed configuration buses
   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_cfg
      assign cfg_width[c*BUSWIDTH +: BUSWIDTH]   = width_q[c];
      assign cfg_height[c*BUSWIDTH +: BUSWIDTH]  = height_q[c];
      assign cfg_rd_addr[c*BUSWIDTH +: BUSWIDTH] = rd_addr_q[c];
      assign cfg_wr_addr[c*BUSWIDTH +: BUSWIDTH] = wr_addr_q[c];
   end
   assign cfg_filter = filter_q;

`ifdef AHB_CFG_READBACK_EN
   logic                rd_go;
   logic [BUSWIDTH-1:0] status_word;
   logic [BUSWIDTH-1:0] rd_value;

   assign rd_go      = dph_go && !dph_write;
   assign status_clr = rd_go && (dph_kind == K_STATUS);

   // STATUS word: run bit, valid mask, sticky error
   always_comb begin
      status_word               = '0;
      status_word[0]            = (state_q == S_RUN);
      status_word[NUM_CHAN:1]   = chan_valid;
      status_word[31]           = sticky_q;
   end

   // Read mux for the register addressed in the current data phase
   always_comb begin
      rd_value = '0;
      if (dph_kind == K_STATUS) begin
         rd_value = status_word;
      end else if (dph_kind == K_CHAN) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            if (dph_ch == 4'(c)) begin
               case (dph_sub)
                  SUB_WIDTH:  rd_value = width_q[c];
                  SUB_HEIGHT: rd_value = height_q[c];
                  SUB_RD:     rd_value = rd_addr_q[c];
                  SUB_WR:     rd_value = wr_addr_q[c];
                  SUB_FILTER: rd_value = {{(BUSWIDTH-1){1'b0}}, filter_q[c]};
                  default:    rd_value = '0;
               endcase
            end
         end
      end
   end

   assign ahb_hrdata = rd_go ? rd_value : '0;
`else
   assign status_clr = 1'b0;
   assign ahb_hrdata = '0;
`endif

endmodule

// File: tb/tb_ahb_cfg_regs.sv
// tb_ahb_cfg_regs: directed plus randomized bench for ahb_cfg_regs. A
// behavioural register-map model predicts response, read data and
// configuration outputs for every transfer.
module tb_ahb_cfg_regs;

   localparam int BW = 32;
   localparam int NC = 2;

`ifdef AHB_CFG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic              ahb_hclk = 1'b0;
   logic              n_rst;
   logic              ahb_hsel;
   logic [1:0]        ahb_htrans;
   logic              ahb_hwrite;
   logic [2:0]        ahb_hsize;
   logic [BW-1:0]     ahb_haddr;
   logic [BW-1:0]     ahb_hwdata;
   logic              ahb_hready_in;
   logic              ahb_hreadyout;
   logic              ahb_hresp;
   logic [BW-1:0]     ahb_hrdata;
   logic [NC*BW-1:0]  cfg_width;
   logic [NC*BW-1:0]  cfg_height;
   logic [NC*BW-1:0]  cfg_rd_addr;
   logic [NC*BW-1:0]  cfg_wr_addr;
   logic [NC-1:0]     cfg_filter;
   logic              final_enable;
   logic              done_i;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_w  [NC];
   logic [31:0] m_h  [NC];
   logic [31:0] m_rd [NC];
   logic [31:0] m_wr [NC];
   bit          m_f  [NC];
   bit          m_wv [NC];
   bit          m_hv [NC];
   bit          m_run;
   bit          m_sticky;

   always #5 ahb_hclk = ~ahb_hclk;

   ahb_cfg_regs #(.BUSWIDTH(BW), .NUM_CHAN(NC)) dut (
      .ahb_hclk      (ahb_hclk),
      .n_rst         (n_rst),
      .ahb_hsel      (ahb_hsel),
      .ahb_htrans    (ahb_htrans),
      .ahb_hwrite    (ahb_hwrite),
      .ahb_hsize     (ahb_hsize),
      .ahb_haddr     (ahb_haddr),
      .ahb_hwdata    (ahb_hwdata),
      .ahb_hready_in (ahb_hready_in),
      .ahb_hreadyout (ahb_hreadyout),
      .ahb_hresp     (ahb_hresp),
      .ahb_hrdata    (ahb_hrdata),
      .cfg_width     (cfg_width),
      .cfg_height    (cfg_height),
      .cfg_rd_addr   (cfg_rd_addr),
      .cfg_wr_addr   (cfg_wr_addr),
      .cfg_filter    (cfg_filter),
      .final_enable  (final_enable),
      .done_i        (done_i)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < NC; c++) begin
         m_w[c] = 0; m_h[c] = 0; m_rd[c] = 0; m_wr[c] = 0;
         m_f[c] = 0; m_wv[c] = 0; m_hv[c] = 0;
      end
      m_run = 0;
      m_sticky = 0;
   endfunction

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = 0;
      s[0] = m_run;
      for (int c = 0; c < NC; c++) s[c+1] = m_wv[c] && m_hv[c];
      s[31] = m_sticky;
      return s;
   endfunction

   // Predict one data phase from the register-map rules and apply its effect.
   function automatic void model_access(input bit wr, input logic [31:0] addr,
                                        input logic [2:0] size, input logic [31:0] data,
                                        input bit done_now, output bit err,
                                        output logic [31:0] rdata);
      int off, c, r;
      bit is_ctrl, is_stat, is_chan, all_v, start;
      logic [31:0] val;
      off = int'(addr[8:0]);
      c = 0; r = 0;
      is_ctrl = (off == 0);
      is_stat = (off == 4);
      is_chan = 0;
      if (off >= 16 && off % 4 == 0) begin
         c = (off - 16) / 32;
         r = (off - 16) % 32;
         is_chan = (c < NC) && (r <= 16);
      end
      all_v = 1;
      for (int k = 0; k < NC; k++) all_v = all_v && m_wv[k] && m_hv[k];
      err = !(is_ctrl || is_stat || is_chan) || (size != 3'b010);
      if (wr) begin
         if (is_stat) err = 1;
         if (is_chan && m_run) err = 1;
         if (is_chan && (r == 0 || r == 4) && data == 0) err = 1;
         if (is_ctrl && data[0] && (m_run || !all_v)) err = 1;
      end
      val = 0;
      if (!wr && !err) begin
         if (is_stat) val = model_status();
         else if (is_chan) begin
            case (r)
               0:  val = m_w[c];
               4:  val = m_h[c];
               8:  val = m_rd[c];
               12: val = m_wr[c];
               default: val = {31'd0, m_f[c]};
            endcase
         end
      end
      rdata = RB ? val : 32'd0;
      start = 0;
      if (err) m_sticky = 1;
      else if (wr) begin
         if (is_ctrl && data[0]) start = 1;
         if (is_chan) begin
            case (r)
               0:  begin m_w[c] = data; m_wv[c] = 1; end
               4:  begin m_h[c] = data; m_hv[c] = 1; end
               8:  m_rd[c] = data;
               12: m_wr[c] = data;
               default: m_f[c] = data[0];
            endcase
         end
      end else if (is_stat && RB) m_sticky = 0;
      if (m_run && done_now) m_run = 0;
      else if (start) m_run = 1;
   endfunction

   task automatic check_cfg(input string tag);
      logic [NC*BW-1:0] ew, eh, er, ea;
      logic [NC-1:0]    ef;
      for (int c = 0; c < NC; c++) begin
         ew[c*BW +: BW] = m_w[c];
         eh[c*BW +: BW] = m_h[c];
         er[c*BW +: BW] = m_rd[c];
         ea[c*BW +: BW] = m_wr[c];
         ef[c] = m_f[c];
      end
      chk({tag, " cfg_width"}, cfg_width, ew);
      chk({tag, " cfg_height"}, cfg_height, eh);
      chk({tag, " cfg_rd_addr"}, cfg_rd_addr, er);
      chk({tag, " cfg_wr_addr"}, cfg_wr_addr, ea);
      chk({tag, " cfg_filter"}, cfg_filter, ef);
      chk({tag, " final_enable"}, final_enable, m_run);
   endtask

   // One single transfer: address phase, data phase, optional ERROR tail.
   task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] data, input bit done_now,
                       output bit err_seen, output logic [31:0] rd);
      bit exp_err, fe_pre;
      logic [31:0] exp_rd;
      logic r1, e1, fe1;
      @(negedge ahb_hclk);
      ahb_hsel = 1; ahb_htrans = 2'b10; ahb_hwrite = wr; ahb_hsize = size; ahb_haddr = addr;
      @(negedge ahb_hclk);
      ahb_hsel = 0; ahb_htrans = 2'b00; ahb_hwdata = data; done_i = done_now;
      #1;
      r1 = ahb_hreadyout; e1 = ahb_hresp; rd = ahb_hrdata; fe1 = final_enable;
      fe_pre = m_run;
      model_access(wr, addr, size, data, done_now, exp_err, exp_rd);
      chk({tag, " hresp"}, e1, exp_err);
      chk({tag, " hreadyout"}, r1, !exp_err);
      chk({tag, " hrdata"}, rd, exp_rd);
      chk({tag, " fe in data phase"}, fe1, fe_pre);
      @(posedge ahb_hclk);
      #1;
      done_i = 0;
      if (exp_err) begin
         @(negedge ahb_hclk);
         #1;
         chk({tag, " err2 hreadyout"}, ahb_hreadyout, 1'b1);
         chk({tag, " err2 hresp"}, ahb_hresp, 1'b1);
      end
      err_seen = e1;
      check_cfg(tag);
   endtask

   // Back-to-back NONSEQ/SEQ write burst over all five registers of channel c.
   task automatic burst(input string tag, input int c);
      logic [31:0] a [5];
      logic [31:0] d [5];
      bit e;
      logic [31:0] r;
      for (int k = 0; k < 5; k++) begin
         a[k] = 32'h10 + 32'(32 * c) + 32'(4 * k);
         d[k] = (k == 4) ? 32'($urandom_range(0, 1)) : ($urandom | 32'd1);
      end
      @(negedge ahb_hclk);
      ahb_hsel = 1; ahb_htrans = 2'b10; ahb_hwrite = 1; ahb_hsize = 3'b010; ahb_haddr = a[0];
      for (int k = 0; k < 5; k++) begin
         @(negedge ahb_hclk);
         ahb_hwdata = d[k];
         if (k < 4) begin
            ahb_htrans = 2'b11; ahb_haddr = a[k+1];
         end else begin
            ahb_hsel = 0; ahb_htrans = 2'b00;
         end
         #1;
         model_access(1, a[k], 3'b010, d[k], 0, e, r);
         chk($sformatf("%s beat%0d hresp", tag, k), ahb_hresp, e);
         chk($sformatf("%s beat%0d hreadyout", tag, k), ahb_hreadyout, !e);
      end
      @(posedge ahb_hclk);
      #1;
      check_cfg(tag);
   endtask

   // Address phase that must not be taken; a zero WIDTH write would error if it were.
   task automatic ignored(input string tag, input logic sel, input logic [1:0] tr, input logic rdy);
      @(negedge ahb_hclk);
      ahb_hsel = sel; ahb_htrans = tr; ahb_hwrite = 1; ahb_hsize = 3'b010;
      ahb_haddr = 32'h10; ahb_hready_in = rdy;
      @(negedge ahb_hclk);
      ahb_hsel = 0; ahb_htrans = 2'b00; ahb_hready_in = 1; ahb_hwdata = 32'h0;
      #1;
      chk({tag, " hresp"}, ahb_hresp, 1'b0);
      chk({tag, " hreadyout"}, ahb_hreadyout, 1'b1);
      @(posedge ahb_hclk);
      #1;
      check_cfg(tag);
   endtask

   task automatic pulse_done(input string tag);
      @(negedge ahb_hclk);
      done_i = 1;
      #1;
      chk({tag, " fe before done edge"}, final_enable, m_run);
      @(posedge ahb_hclk);
      #1;
      done_i = 0;
      m_run = 0;
      check_cfg(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit e;
      logic [31:0] rd, addr, data;
      logic [2:0] size;
      bit wr;
      int sel;

      n_rst = 0; ahb_hsel = 0; ahb_htrans = 2'b00; ahb_hwrite = 0; ahb_hsize = 3'b010;
      ahb_haddr = 0; ahb_hwdata = 0; ahb_hready_in = 1; done_i = 0;
      model_reset();
      #1;
      check_cfg("reset");
      chk("reset hreadyout", ahb_hreadyout, 1'b1);
      chk("reset hresp", ahb_hresp, 1'b0);
      chk("reset hrdata", ahb_hrdata, 32'd0);
      repeat (3) @(negedge ahb_hclk);
      n_rst = 1;

      // Channel 0 only valid, START must be refused
      xfer("ch0 width", 1, 32'hABC0_0010, 3'b010, 32'd640, 0, e, rd);
      chk("ch0 width okay", e, 1'b0);
      xfer("ch0 height", 1, 32'h14, 3'b010, 32'd480, 0, e, rd);
      xfer("start ch0 only", 1, 32'h0, 3'b010, 32'd1, 0, e, rd);
      chk("start ch0 only err", e, 1'b1);
      chk("fe after bad start", final_enable, 1'b0);
      xfer("status read 1", 0, 32'h4, 3'b010, 32'd0, 0, e, rd);
`ifdef AHB_CFG_READBACK_EN
      chk("status sticky set", rd, 32'h8000_0002);
`endif
      xfer("status read 2", 0, 32'h4, 3'b010, 32'd0, 0, e, rd);
`ifdef AHB_CFG_READBACK_EN
      chk("status sticky cleared", rd, 32'h0000_0002);
`endif

      // Zero WIDTH and byte-sized write are both errors
      xfer("width zero", 1, 32'h10, 3'b010, 32'd0, 0, e, rd);
      chk("width zero err", e, 1'b1);
      xfer("byte write", 1, 32'h10, 3'b000, 32'h55, 0, e, rd);
      chk("byte write err", e, 1'b1);
      chk("ch0 width kept", cfg_width[31:0], 32'd640);

      // Channel 1, then a legal START
      xfer("ch1 width", 1, 32'h30, 3'b010, 32'd320, 0, e, rd);
      xfer("ch1 height", 1, 32'h34, 3'b010, 32'd240, 0, e, rd);
      xfer("start ok", 1, 32'h0, 3'b010, 32'd1, 0, e, rd);
      chk("start ok resp", e, 1'b0);
      chk("fe after start", final_enable, 1'b1);

      // RUN: channel writes refused, reads fine, second START refused
      xfer("rd_addr in run", 1, 32'h38, 3'b010, 32'h1000, 0, e, rd);
      chk("rd_addr in run err", e, 1'b1);
      chk("ch1 rd_addr kept", cfg_rd_addr[63:32], 32'd0);
      xfer("read in run", 0, 32'h10, 3'b010, 32'd0, 0, e, rd);
      xfer("start in run", 1, 32'h0, 3'b010, 32'd1, 0, e, rd);
      pulse_done("done in run");
      chk("fe after done", final_enable, 1'b0);
      pulse_done("done in idle");

      // Back-to-back SEQ bursts
      burst("burst ch0", 0);
      burst("burst ch1", 1);

      // START coincident with done_i in RUN
      xfer("start 2", 1, 32'h0, 3'b010, 32'd1, 0, e, rd);
      xfer("start with done", 1, 32'h0, 3'b010, 32'd1, 1, e, rd);
      chk("start with done err", e, 1'b1);
      chk("fe after start with done", final_enable, 1'b0);

      // Transfers that must be ignored
      ignored("busy", 1'b1, 2'b01, 1'b1);
      ignored("idle", 1'b1, 2'b00, 1'b1);
      ignored("hready_in low", 1'b1, 2'b10, 1'b0);
      ignored("hsel low", 1'b0, 2'b10, 1'b1);

      // Map edges
      xfer("read 0x008", 0, 32'h8, 3'b010, 32'd0, 0, e, rd);
      xfer("read 0x00c", 0, 32'hC, 3'b010, 32'd0, 0, e, rd);
      xfer("unaligned", 1, 32'h12, 3'b010, 32'd7, 0, e, rd);
      xfer("ch0 gap 0x024", 0, 32'h24, 3'b010, 32'd0, 0, e, rd);
      xfer("past last chan", 1, 32'h50, 3'b010, 32'd9, 0, e, rd);
      xfer("ch1 filter", 1, 32'h40, 3'b010, 32'd1, 0, e, rd);
      xfer("ch1 filter read", 0, 32'h40, 3'b010, 32'd0, 0, e, rd);
      xfer("ctrl alias read", 0, 32'h200, 3'b010, 32'd0, 0, e, rd);
      xfer("status write", 1, 32'h4, 3'b010, 32'd0, 0, e, rd);
      xfer("ctrl write 0", 1, 32'h0, 3'b010, 32'd0, 0, e, rd);
      xfer("dword read", 0, 32'h18, 3'b011, 32'd0, 0, e, rd);

      // Randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         if (m_run && $urandom_range(0, 4) == 0) begin
            pulse_done($sformatf("rand%0d done", i));
         end else begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
               addr = 32'h0; wr = 1; data = 32'($urandom_range(0, 1));
            end else begin
               addr = 32'($urandom_range(0, 'h6F));
               if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
               wr = 1'($urandom_range(0, 1));
               data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            xfer($sformatf("rand%0d", i), wr, addr, size, data, 0, e, rd);
         end
      end

      // Reset while running
      if (!m_run) xfer("start before reset", 1, 32'h0, 3'b010, 32'd1, 0, e, rd);
      #2;
      n_rst = 0;
      model_reset();
      #1;
      check_cfg("reset in run");
      chk("reset in run hreadyout", ahb_hreadyout, 1'b1);
      chk("reset in run hresp", ahb_hresp, 1'b0);
      chk("reset in run hrdata", ahb_hrdata, 32'd0);
      @(negedge ahb_hclk);
      n_rst = 1;
      xfer("status after reset", 0, 32'h4, 3'b010, 32'd0, 0, e, rd);

      // Reset in the middle of an ERROR response
      @(negedge ahb_hclk);
      ahb_hsel = 1; ahb_htrans = 2'b10; ahb_hwrite = 0; ahb_hsize = 3'b010; ahb_haddr = 32'h8;
      @(negedge ahb_hclk);
      ahb_hsel = 0; ahb_htrans = 2'b00;
      #1;
      chk("err cycle1 hresp", ahb_hresp, 1'b1);
      chk("err cycle1 hreadyout", ahb_hreadyout, 1'b0);
      n_rst = 0;
      #1;
      chk("err abandoned hresp", ahb_hresp, 1'b0);
      chk("err abandoned hreadyout", ahb_hreadyout, 1'b1);
      @(negedge ahb_hclk);
      n_rst = 1;
      @(negedge ahb_hclk);
      #1;
      chk("after abandon hresp", ahb_hresp, 1'b0);
      xfer("status after abandon", 0, 32'h4, 3'b010, 32'd0, 0, e, rd);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
